matrix_blk_sched: RTL and testbench
===================================

// Module: matrix_blk_sched
// PURPOSE
//  Sequencer for the 64x10 weight-matrix path of the PE1X64 array. Latches one full
//  ROWSxCOLS matrix on start, slices it into NBLK row blocks, and issues them one at a time
//  to the PE array over a valid/ready handshake. It waits for pe_done before issuing the
//  next block, then pulses finish. Replaces the one-shot split with a flow-controlled schedule.
// PARAMETERS
//  ELEM_W  16  signed element width in bits
//  ROWS    64  matrix rows
//  COLS    10  matrix columns
//  NBLK    4   row blocks; ROWS % NBLK == 0; block = (ROWS/NBLK)xCOLS
//  MAT_W   ROWS*COLS*ELEM_W (10240), localparam
//  BLK_W   MAT_W/NBLK (2560), localparam
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  start      in   1       1-cycle request; accepted only in IDLE
//  Matrix     in   MAT_W   signed matrix, sampled on the accepted start cycle
//  blk_data   out  BLK_W   current block; block k = Matrix[MAT_W-1-k*BLK_W -: BLK_W]
//  blk_idx    out  clog2(NBLK) index of the block on blk_data
//  blk_valid  out  1       blk_data/blk_idx valid
//  blk_ready  in   1       PE array accepts block when blk_valid&&blk_ready
//  pe_done    in   1       1-cycle pulse: PE finished the accepted block
//  busy       out  1       high from accepted start until finish is pulsed
//  finish     out  1       1-cycle pulse after the last block's pe_done
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; blk_data=0, blk_idx=0, blk_valid=0, busy=0,
//   finish=0; internal matrix register cleared. Outputs take reset values without a clock edge.
//  FSM, all transitions on posedge clk:
//   IDLE : start=1 -> latch Matrix, blk_idx<=0, busy<=1 -> ISSUE.
//   ISSUE: blk_valid=1, blk_data=slice(blk_idx). Valid rises 1 cycle after start.
//          blk_valid&&blk_ready -> blk_valid<=0 -> WAIT. Data is held stable while ready=0.
//   WAIT : pe_done=1 -> if blk_idx==NBLK-1: finish<=1, busy<=0 -> IDLE;
//          else blk_idx<=blk_idx+1 -> ISSUE.
//  Minimum latency start->finish: NBLK*2+1 cycles (ready tied 1, pe_done 1 cycle after accept).
//  Block order: blk_idx 0 = MSB slice (first in the {c_0,c_1,c_2,c_3} concatenation).
//  Boundary rules:
//   - start while busy: ignored; latched matrix and progress unaffected.
//   - Matrix changes after start: no effect until the next accepted start.
//   - pe_done in IDLE or ISSUE: ignored; it is not counted or queued.
//   - pe_done in the same cycle as the handshake: ignored, because the FSM is still in ISSUE.
//   - finish cycle: state is already IDLE next cycle; a start in that cycle is accepted
//     (back-to-back runs).
//   - blk_idx saturates by construction; never exceeds NBLK-1.
//   - rst low mid-run: immediate abort to reset values; no finish pulse.
//  blk_data is driven from a registered slice; no combinational path from inputs to outputs.
//  Pure data movement; no arithmetic on elements; sign is preserved bit-exact.
// TESTING
//  1 Reset: rst=0 with random inputs -> all outputs 0; release, idle 5 cycles -> no valid.
//  2 Nominal: Matrix = element value row*COLS+col, start, ready=1, pe_done 1 cycle after
//    each accept -> 4 blocks with idx 0..3, each equals the expected 2560b slice; finish at cycle 9.
//  3 Backpressure: ready=0 for 7 cycles on block 2 -> valid held, data/idx stable, single
//    accept when ready=1.
//  4 Spurious/overlap: start pulses and changed Matrix mid-run, pe_done pulses in ISSUE ->
//    output identical to test 2; exactly one finish.
//  5 Async reset mid-run: rst=0 between clock edges during WAIT of block 1 -> outputs 0
//    immediately; the next start restarts at idx 0.
//  6 Back-to-back: start in the finish cycle with a new matrix -> second run blocks match
//    the new matrix; busy stays low for only 1 cycle.

Source files
------------

// File: rtl/matrix_blk_sched_if.sv
// Bundle between the block scheduler and its surroundings: matrix load/start, the
// block valid/ready handshake toward the PE array, completion and status.
interface matrix_blk_sched_if #(
  parameter int ELEM_W = 16,
  parameter int ROWS   = 64,
  parameter int COLS   = 10,
  parameter int NBLK   = 4
);
  localparam int MAT_W = ROWS * COLS * ELEM_W;
  localparam int BLK_W = MAT_W / NBLK;
  localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  // Handshake: a block transfers on every clock edge where blk_valid && blk_ready;
  // while blk_valid is high and blk_ready low, blk_data/blk_idx hold steady and
  // blk_valid never drops. pe_done is a one-cycle pulse from the PE array.
  logic             start;
  logic [MAT_W-1:0] Matrix;
  logic [BLK_W-1:0] blk_data;
  logic [IDX_W-1:0] blk_idx;
  logic             blk_valid;
  logic             blk_ready;
  logic             pe_done;
  logic             busy;
  logic             finish;
  logic [1:0]       dbg_state;

  modport master (
    output start, Matrix, blk_ready, pe_done,
    input  blk_data, blk_idx, blk_valid, busy, finish, dbg_state
  );

  modport slave (
    input  start, Matrix, blk_ready, pe_done,
    output blk_data, blk_idx, blk_valid, busy, finish, dbg_state
  );
endinterface

// File: rtl/matrix_blk_sched.sv
// Latches a ROWSxCOLS matrix on start and issues it to the PE array as NBLK row
// blocks, one at a time, waiting for pe_done after each accepted block.
module matrix_blk_sched #(
  parameter int ELEM_W = 16,
  parameter int ROWS   = 64,
  parameter int COLS   = 10,
  parameter int NBLK   = 4
) (
  input  logic                clk,
  input  logic                rst,
  matrix_blk_sched_if.slave   bus
);
  localparam int MAT_W = ROWS * COLS * ELEM_W;
  localparam int BLK_W = MAT_W / NBLK;
  localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MAT_W-1:0] r_matrix;
  logic [MAT_W-1:0] w_matrix_nxt;
  logic [BLK_W-1:0] r_blk_data;
  logic [BLK_W-1:0] w_blk_data_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_idx_inc;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_finish;
  logic             w_finish_nxt;
  logic             w_last;
  logic [BLK_W-1:0] w_slice [NBLK];

  // Block k is the k-th slice counted from the MSB end of the latched matrix.
  for (genvar k = 0; k < NBLK; k++) begin : g_slice
    assign w_slice[k] = r_matrix[MAT_W-1-k*BLK_W -: BLK_W];
  end

  assign w_last    = (r_idx == IDX_W'(NBLK - 1));
  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_matrix_nxt   = r_matrix;
    w_blk_data_nxt = r_blk_data;
    w_idx_nxt      = r_idx;
    w_valid_nxt    = r_valid;
    w_busy_nxt     = r_busy;
    w_finish_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_matrix_nxt   = bus.Matrix;
          w_blk_data_nxt = bus.Matrix[MAT_W-1 -: BLK_W];
          w_idx_nxt      = '0;
          w_valid_nxt    = 1'b1;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.blk_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // pe_done only counts here, so pulses outside WAIT are simply dropped.
        if (bus.pe_done) begin
          if (w_last) begin
            w_finish_nxt = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_idx_nxt      = w_idx_inc;
            w_blk_data_nxt = w_slice[w_idx_inc];
            w_valid_nxt    = 1'b1;
            w_state_nxt    = S_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_matrix   <= '0;
      r_blk_data <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_matrix   <= w_matrix_nxt;
      r_blk_data <= w_blk_data_nxt;
      r_idx      <= w_idx_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_finish   <= w_finish_nxt;
    end
  end

  assign bus.blk_data  = r_blk_data;
  assign bus.blk_idx   = r_idx;
  assign bus.blk_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.finish    = r_finish;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_matrix_blk_sched.sv
// Directed bench for matrix_blk_sched: reset, nominal schedule, backpressure,
// spurious inputs, asynchronous abort and back-to-back runs.
module tb_matrix_blk_sched;
  localparam int ELEM_W = 16;
  localparam int ROWS   = 64;
  localparam int COLS   = 10;
  localparam int NBLK   = 4;
  localparam int MAT_W  = ROWS * COLS * ELEM_W;
  localparam int BLK_W  = MAT_W / NBLK;
  localparam int IDX_W  = 2;
  localparam int BLK_EL = (ROWS / NBLK) * COLS;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  matrix_blk_sched_if #(.ELEM_W(ELEM_W), .ROWS(ROWS), .COLS(COLS), .NBLK(NBLK)) bus ();

  matrix_blk_sched #(.ELEM_W(ELEM_W), .ROWS(ROWS), .COLS(COLS), .NBLK(NBLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row-major, element (0,0) in the most significant ELEM_W bits; value = base + row*COLS+col.
  function automatic logic [MAT_W-1:0] make_mat(input int base);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS * COLS; i++) m[MAT_W-1-i*ELEM_W -: ELEM_W] = ELEM_W'(base + i);
    return m;
  endfunction

  function automatic logic [BLK_W-1:0] slice(input logic [MAT_W-1:0] m, input int k);
    return m[MAT_W-1-k*BLK_W -: BLK_W];
  endfunction

  task automatic test_reset();
    logic [MAT_W-1:0] m;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < MAT_W / 32; i++) m[i*32 +: 32] = $urandom;
      bus.Matrix    = m;
      bus.start     = 1'($urandom_range(0, 1));
      bus.blk_ready = 1'($urandom_range(0, 1));
      bus.pe_done   = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if ({bus.blk_valid, bus.busy, bus.finish} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_ctrl: valid/busy/finish=%b required 000", {bus.blk_valid, bus.busy, bus.finish});
      end
      n_cmp++;
      if (bus.blk_data !== '0 || bus.blk_idx !== '0 || bus.dbg_state !== 2'd0) begin
        n_err++;
        $display("FAIL reset_data: data_top=%h idx=%0d state=%0d required 0/0/0",
                 bus.blk_data[BLK_W-1 -: 64], bus.blk_idx, bus.dbg_state);
      end
    end
    bus.start = 1'b0; bus.pe_done = 1'b0; bus.blk_ready = 1'b1; bus.Matrix = '0;
    rst = 1'b1;
    repeat (5) begin
      tick();
      n_cmp++;
      if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: valid=%b busy=%b required 0 0", bus.blk_valid, bus.busy);
      end
    end
  endtask

  task automatic test_nominal();
    logic [MAT_W-1:0] m;
    m = make_mat(0);
    bus.Matrix = m; bus.blk_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      n_cmp++;
      if (bus.blk_valid !== 1'b1 || bus.blk_idx !== IDX_W'(k) || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL nom_issue k=%0d: valid=%b idx=%0d busy=%b required 1 %0d 1", k, bus.blk_valid, bus.blk_idx, bus.busy, k);
      end
      n_cmp++;
      if (bus.blk_data !== slice(m, k)) begin
        n_err++;
        $display("FAIL nom_data k=%0d: top=%h required %h (%0d bits differ)", k, bus.blk_data[BLK_W-1 -: 64],
                 slice(m, k) >> (BLK_W - 64), $countones(bus.blk_data ^ slice(m, k)));
      end
      n_cmp++;
      if (bus.blk_data[BLK_W-1 -: ELEM_W] !== ELEM_W'(k * BLK_EL) || bus.blk_data[ELEM_W-1:0] !== ELEM_W'(k * BLK_EL + BLK_EL - 1)) begin
        n_err++;
        $display("FAIL nom_elem k=%0d: first=%0d last=%0d required %0d %0d", k, bus.blk_data[BLK_W-1 -: ELEM_W],
                 bus.blk_data[ELEM_W-1:0], k * BLK_EL, k * BLK_EL + BLK_EL - 1);
      end
      tick();
      n_cmp++;
      if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b1 || bus.finish !== 1'b0) begin
        n_err++;
        $display("FAIL nom_wait k=%0d: valid=%b busy=%b finish=%b required 0 1 0", k, bus.blk_valid, bus.busy, bus.finish);
      end
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
    end
    // Nine cycles after the start cycle.
    n_cmp++;
    if (bus.finish !== 1'b1 || bus.busy !== 1'b0 || bus.blk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL nom_finish: finish=%b busy=%b valid=%b required 1 0 0", bus.finish, bus.busy, bus.blk_valid);
    end
    tick();
    n_cmp++;
    if (bus.finish !== 1'b0 || bus.dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL nom_finish_pulse: finish=%b state=%0d required 0 0", bus.finish, bus.dbg_state);
    end
  endtask

  task automatic test_backpressure();
    logic [MAT_W-1:0] m;
    m = make_mat(1000);
    bus.Matrix = m; bus.blk_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      n_cmp++;
      if (bus.blk_valid !== 1'b1 || bus.blk_idx !== IDX_W'(k) || bus.blk_data !== slice(m, k)) begin
        n_err++;
        $display("FAIL bp_issue k=%0d: valid=%b idx=%0d data_top=%h required 1 %0d %h", k, bus.blk_valid,
                 bus.blk_idx, bus.blk_data[BLK_W-1 -: 64], k, slice(m, k) >> (BLK_W - 64));
      end
      if (k == 2) begin
        bus.blk_ready = 1'b0;
        repeat (7) begin
          tick();
          n_cmp++;
          if (bus.blk_valid !== 1'b1 || bus.blk_idx !== 2'd2 || bus.blk_data !== slice(m, 2)) begin
            n_err++;
            $display("FAIL bp_hold: valid=%b idx=%0d data_top=%h required 1 2 %h", bus.blk_valid, bus.blk_idx,
                     bus.blk_data[BLK_W-1 -: 64], slice(m, 2) >> (BLK_W - 64));
          end
        end
        bus.blk_ready = 1'b1;
      end
      tick();
      n_cmp++;
      if (bus.blk_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_accept k=%0d: valid=%b required 0", k, bus.blk_valid);
      end
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
    end
    n_cmp++;
    if (bus.finish !== 1'b1) begin
      n_err++;
      $display("FAIL bp_finish: finish=%b required 1", bus.finish);
    end
    tick();
  endtask

  task automatic test_spurious();
    logic [MAT_W-1:0] m;
    m = make_mat(0);
    bus.blk_ready = 1'b1;
    bus.pe_done = 1'b1;
    tick();
    bus.pe_done = 1'b0;
    n_cmp++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL sp_idle_done: valid=%b busy=%b required 0 0", bus.blk_valid, bus.busy);
    end
    bus.Matrix = m; bus.start = 1'b1;
    tick();
    for (int k = 0; k < NBLK; k++) begin
      bus.pe_done = 1'b1; bus.start = 1'b1; bus.Matrix = ~m;
      n_cmp++;
      if (bus.blk_valid !== 1'b1 || bus.blk_idx !== IDX_W'(k) || bus.blk_data !== slice(m, k)) begin
        n_err++;
        $display("FAIL sp_issue k=%0d: valid=%b idx=%0d data_top=%h required 1 %0d %h", k, bus.blk_valid,
                 bus.blk_idx, bus.blk_data[BLK_W-1 -: 64], k, slice(m, k) >> (BLK_W - 64));
      end
      tick();
      bus.pe_done = 1'b0;
      tick();
      // The handshake-cycle pe_done must not have advanced the schedule.
      n_cmp++;
      if (bus.blk_valid !== 1'b0 || bus.finish !== 1'b0 || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL sp_wait k=%0d: valid=%b finish=%b busy=%b required 0 0 1", k, bus.blk_valid, bus.finish, bus.busy);
      end
      bus.pe_done = 1'b1; bus.start = 1'b0;
      tick();
      bus.pe_done = 1'b0;
    end
    n_cmp++;
    if (bus.finish !== 1'b1) begin
      n_err++;
      $display("FAIL sp_finish: finish=%b required 1", bus.finish);
    end
    tick();
    n_cmp++;
    if (bus.finish !== 1'b0 || bus.busy !== 1'b0 || bus.blk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sp_single_finish: finish=%b busy=%b valid=%b required 0 0 0", bus.finish, bus.busy, bus.blk_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [MAT_W-1:0] m;
    m = make_mat(2000);
    bus.Matrix = m; bus.blk_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.pe_done = 1'b1;
    tick();
    bus.pe_done = 1'b0;
    tick();
    n_cmp++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b1 || bus.blk_idx !== 2'd1) begin
      n_err++;
      $display("FAIL ar_pre: valid=%b busy=%b idx=%0d required 0 1 1", bus.blk_valid, bus.busy, bus.blk_idx);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.blk_valid, bus.busy, bus.finish} !== 3'b000 || bus.blk_idx !== '0 || bus.blk_data !== '0 || bus.dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL ar_immediate: valid/busy/finish=%b idx=%0d data_top=%h state=%0d required 000 0 0 0",
               {bus.blk_valid, bus.busy, bus.finish}, bus.blk_idx, bus.blk_data[BLK_W-1 -: 64], bus.dbg_state);
    end
    tick();
    rst = 1'b1;
    m = make_mat(3000);
    bus.Matrix = m; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.blk_valid !== 1'b1 || bus.blk_idx !== 2'd0 || bus.blk_data !== slice(m, 0) || bus.finish !== 1'b0) begin
      n_err++;
      $display("FAIL ar_restart: valid=%b idx=%0d finish=%b data_top=%h required 1 0 0 %h", bus.blk_valid,
               bus.blk_idx, bus.finish, bus.blk_data[BLK_W-1 -: 64], slice(m, 0) >> (BLK_W - 64));
    end
    for (int k = 0; k < NBLK; k++) begin
      tick();
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
    end
    n_cmp++;
    if (bus.finish !== 1'b1) begin
      n_err++;
      $display("FAIL ar_run_finish: finish=%b required 1", bus.finish);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [MAT_W-1:0] ma;
    logic [MAT_W-1:0] mb;
    ma = make_mat(500);
    mb = make_mat(-300);
    bus.Matrix = ma; bus.blk_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      tick();
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
    end
    n_cmp++;
    if (bus.finish !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first_finish: finish=%b busy=%b required 1 0", bus.finish, bus.busy);
    end
    bus.Matrix = mb; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.blk_valid !== 1'b1 || bus.blk_idx !== IDX_W'(k) || bus.blk_data !== slice(mb, k)) begin
        n_err++;
        $display("FAIL b2b_issue k=%0d: busy=%b valid=%b idx=%0d data_top=%h required 1 1 %0d %h", k, bus.busy,
                 bus.blk_valid, bus.blk_idx, bus.blk_data[BLK_W-1 -: 64], k, slice(mb, k) >> (BLK_W - 64));
      end
      n_cmp++;
      if (bus.blk_data[BLK_W-1 -: ELEM_W] !== ELEM_W'(-300 + k * BLK_EL)) begin
        n_err++;
        $display("FAIL b2b_elem k=%0d: first=%h required %h", k, bus.blk_data[BLK_W-1 -: ELEM_W], ELEM_W'(-300 + k * BLK_EL));
      end
      tick();
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
    end
    n_cmp++;
    if (bus.finish !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second_finish: finish=%b busy=%b required 1 0", bus.finish, bus.busy);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.Matrix = '0;
    bus.blk_ready = 1'b0;
    bus.pe_done = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_spurious();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
